// File: rtl/hangman_pkg.sv
// Shared scan-code constants, letter type and prefix-state encoding for the
// hangman keyboard decoder.
package hangman_pkg;

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } prefix_state_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_END    = 8'h69;
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_DELETE = 8'h71;

    localparam int K_ENTER  = 0;
    localparam int K_END    = 1;
    localparam int K_HOME   = 2;
    localparam int K_DELETE = 3;

    // One-hot command key for a terminal byte; Enter is a plain code, the
    // other three only exist behind an E0 prefix.
    function automatic logic [3:0] key_mask(input logic [7:0] code,
                                            input logic ext);
        logic [3:0] m;
        m = '0;
        if (!ext && code == SC_ENTER)     m[K_ENTER]  = 1'b1;
        if (ext && code == SC_END)        m[K_END]    = 1'b1;
        if (ext && code == SC_HOME)       m[K_HOME]   = 1'b1;
        if (ext && code == SC_DELETE)     m[K_DELETE] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/hangman_letter_lut.sv
// Combinational set-2 scan code to letter index (A=0 .. Z=25) lookup.
module hangman_letter_lut
    import hangman_pkg::*;
(
    input  logic [7:0] code,
    output logic       hit,
    output letter_t    idx
);

    always_comb begin
        hit = 1'b1;
        idx = '0;
        case (code)
            8'h1C: idx = 5'd0;
            8'h32: idx = 5'd1;
            8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;
            8'h24: idx = 5'd4;
            8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;
            8'h33: idx = 5'd7;
            8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;
            8'h42: idx = 5'd10;
            8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;
            8'h31: idx = 5'd13;
            8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;
            8'h15: idx = 5'd16;
            8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;
            8'h2C: idx = 5'd19;
            8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;
            8'h1D: idx = 5'd22;
            8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;
            8'h1A: idx = 5'd25;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/hangman_key_decoder.sv
// PS/2 set-2 byte stream to hangman commands: letter level + command pulses.
// Optional prefix watchdog enabled by defining KEYDEC_PREFIX_TIMEOUT_EN.
module hangman_key_decoder
    import hangman_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       load,
    output logic [4:0] letter,
    output logic       endinput,
    output logic       start,
    output logic       wipe,
    output logic       try
);

    prefix_state_t state_q, state_d;
    logic          load_q, load_d;
    letter_t       letter_q, letter_d;
    logic [3:0]    down_q, down_d;
    logic [3:0]    pulse_q, pulse_d;
    logic          lut_hit;
    letter_t       lut_idx;
    logic          tmo;
    logic [3:0]    mask;

    hangman_letter_lut u_lut (
        .code (scan_code),
        .hit  (lut_hit),
        .idx  (lut_idx)
    );

`ifdef KEYDEC_PREFIX_TIMEOUT_EN
    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        tmo   = 1'b0;
        if (!scan_valid && state_q != S_IDLE) begin
            if (cnt_q == CW'(PREFIX_TIMEOUT - 1)) tmo = 1'b1;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^PREFIX_TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            if (scan_code == SC_E0)
                state_d = S_E0;
            else if (scan_code == SC_F0)
                state_d = (state_q == S_E0 || state_q == S_E0F0) ? S_E0F0 : S_F0;
            else
                state_d = S_IDLE;
        end else if (tmo) begin
            state_d = S_IDLE;
        end
    end

    // Effects only fire on terminal bytes; prefix bytes just move the FSM.
    always_comb begin
        load_d   = load_q;
        letter_d = letter_q;
        down_d   = down_q;
        pulse_d  = '0;
        mask     = key_mask(scan_code, state_q == S_E0 || state_q == S_E0F0);
        if (scan_valid && scan_code != SC_E0 && scan_code != SC_F0) begin
            unique case (state_q)
                S_IDLE: begin
                    if (lut_hit) begin
                        letter_d = lut_idx;
                        load_d   = 1'b1;
                    end
                    pulse_d = mask & ~down_q;
                    down_d  = down_q | mask;
                end
                S_F0: begin
                    if (lut_hit && lut_idx == letter_q) load_d = 1'b0;
                    down_d = down_q & ~mask;
                end
                S_E0: begin
                    pulse_d = mask & ~down_q;
                    down_d  = down_q | mask;
                end
                S_E0F0: down_d = down_q & ~mask;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            load_q   <= 1'b0;
            letter_q <= '0;
            down_q   <= '0;
            pulse_q  <= '0;
        end else begin
            load_q   <= load_d;
            letter_q <= letter_d;
            down_q   <= down_d;
            pulse_q  <= pulse_d;
        end
    end

    assign load     = load_q;
    assign letter   = letter_q;
    assign try      = pulse_q[K_ENTER];
    assign endinput = pulse_q[K_END];
    assign start    = pulse_q[K_HOME];
    assign wipe     = pulse_q[K_DELETE];

endmodule
